vga_timing: RTL and testbench

- Pixel-timing generator for the screensaver's 640x480@60 VGA output.
- Sits directly upstream of the image stage and drives its inputs: current position, next-cycle position and frame counter.
- Also drives the panel sync pins and a visible-area flag, both cycle-aligned with the image stage's registered r/g/b.
- clk is the pixel clock (25.175 MHz nominal); one pixel per clk.

---
 rtl/vga_timing.sv | 86 ++++++++
 tb/tb_vga_timing.sv | 139 +++++++++++++
 2 files changed

// File: rtl/vga_timing.sv
// 640x480@60 raster generator: next-position counters are the primary state, current position and syncs lag by one clk.
// Outputs are all registered so sync/visible line up with an image stage that registers colour from the *_NEXT position.
module vga_timing #(
  parameter int   H_ACTIVE  = 640,
  parameter int   H_FP      = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BP      = 48,
  parameter int   V_ACTIVE  = 480,
  parameter int   V_FP      = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BP      = 33,
  parameter logic HSYNC_POL = 1'b0,
  parameter logic VSYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [9:0]  position_x,
  output logic [8:0]  position_y,
  output logic [9:0]  position_x_NEXT,
  output logic [8:0]  position_y_NEXT,
  output logic [31:0] frame,
  output logic        hsync,
  output logic        vsync,
  output logic        visible,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] hn, vn;
  logic [9:0] hn_nx, vn_nx;
  logic       line_end, frame_end, at_origin;

  always_comb begin
    line_end  = (hn == H_LAST);
    frame_end = line_end && (vn == V_LAST);
    at_origin = (hn == 10'd0) && (vn == 10'd0);
    hn_nx     = line_end ? 10'd0 : hn + 10'd1;
    vn_nx     = vn;
    if (frame_end)
      vn_nx = 10'd0;
    else if (line_end)
      vn_nx = vn + 10'd1;
  end

  // Every "current" output is the registered image of the next-position state,
  // so it describes the pixel the image stage presents in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hn          <= 10'd1;
      vn          <= 10'd0;
      position_x  <= 10'd0;
      position_y  <= 9'd0;
      frame       <= 32'd0;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      visible     <= 1'b1;
      frame_start <= 1'b1;
    end else begin
      hn          <= hn_nx;
      vn          <= vn_nx;
      position_x  <= hn;
      position_y  <= vn[8:0];
      hsync       <= ((hn >= HS_START) && (hn < HS_END)) ? HSYNC_POL : ~HSYNC_POL;
      vsync       <= ((vn >= VS_START) && (vn < VS_END)) ? VSYNC_POL : ~VSYNC_POL;
      visible     <= (hn < H_VIS) && (vn < V_VIS);
      frame_start <= at_origin;
      if (at_origin)
        frame <= frame + 32'd1;
    end
  end

  assign position_x_NEXT = hn;
  assign position_y_NEXT = vn[8:0];

endmodule

// File: tb/tb_vga_timing.sv
// Bench: full-size and shortened-raster instances compared every cycle against an arithmetic raster model.
module tb_vga_timing;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int t;

  // Full-size 640x480 instance
  logic [9:0]  b_px, b_pxn;
  logic [8:0]  b_py, b_pyn;
  logic [31:0] b_fr;
  logic        b_hs, b_vs, b_vis, b_fs;

  vga_timing dut_big (
    .clk(clk), .rst_n(rst_n),
    .position_x(b_px), .position_y(b_py),
    .position_x_NEXT(b_pxn), .position_y_NEXT(b_pyn),
    .frame(b_fr), .hsync(b_hs), .vsync(b_vs),
    .visible(b_vis), .frame_start(b_fs)
  );

  // Short lines but more than 512 lines, so whole frames and the 9-bit y wrap fit in a short run
  localparam int S_HA = 8,   S_HF = 2, S_HS = 4, S_HB = 2;
  localparam int S_VA = 496, S_VF = 6, S_VS = 2, S_VB = 10;
  localparam int S_HT = S_HA + S_HF + S_HS + S_HB;
  localparam int S_VT = S_VA + S_VF + S_VS + S_VB;
  localparam int S_F  = S_HT * S_VT;

  logic [9:0]  s_px, s_pxn;
  logic [8:0]  s_py, s_pyn;
  logic [31:0] s_fr;
  logic        s_hs, s_vs, s_vis, s_fs;

  vga_timing #(
    .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
  ) dut_small (
    .clk(clk), .rst_n(rst_n),
    .position_x(s_px), .position_y(s_py),
    .position_x_NEXT(s_pxn), .position_y_NEXT(s_pyn),
    .frame(s_fr), .hsync(s_hs), .vsync(s_vs),
    .visible(s_vis), .frame_start(s_fs)
  );

  // Stand-in image stage: 4x4 checkerboard colour registered from the NEXT position
  logic b_pix, s_pix;
  always_ff @(posedge clk) begin
    b_pix <= b_pxn[2] ^ b_pyn[2];
    s_pix <= s_pxn[2] ^ s_pyn[2];
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs == exp)
      n_pass++;
    else
      $display("FAIL %s: got %0d expected %0d (t=%0d)", tag, obs, exp, t);
  endtask

  // Expected outputs from the elapsed pixel count since reset release.
  task automatic check_dut(input string p, input int ht, input int vt, input int ha, input int va,
                           input int hs0, input int hs1, input int vs0, input int vs1, input int tt,
                           input logic [9:0] px, input logic [9:0] pxn, input logic [8:0] py,
                           input logic [8:0] pyn, input logic [31:0] fr, input logic hs,
                           input logic vs, input logic vis, input logic fs, input logic pix,
                           input bit chk_pix);
    int h, v, hn, vn, f;
    h  = tt % ht;
    v  = (tt / ht) % vt;
    f  = tt / (ht * vt);
    hn = (tt + 1) % ht;
    vn = ((tt + 1) / ht) % vt;
    check({p, ".x"},       px,  h);
    check({p, ".y"},       py,  v % 512);
    check({p, ".x_next"},  pxn, hn);
    check({p, ".y_next"},  pyn, vn % 512);
    check({p, ".frame"},   fr,  f);
    check({p, ".hsync"},   hs,  (h >= hs0 && h < hs1) ? 0 : 1);
    check({p, ".vsync"},   vs,  (v >= vs0 && v < vs1) ? 0 : 1);
    check({p, ".visible"}, vis, (h < ha && v < va) ? 1 : 0);
    check({p, ".fstart"},  fs,  (h == 0 && v == 0) ? 1 : 0);
    if (chk_pix)
      check({p, ".pix"},   pix, ((h / 4) + ((v % 512) / 4)) % 2);
  endtask

  task automatic check_all(input bit chk_pix);
    check_dut("big", 800, 525, 640, 480, 656, 752, 490, 492, t,
              b_px, b_pxn, b_py, b_pyn, b_fr, b_hs, b_vs, b_vis, b_fs, b_pix, chk_pix);
    check_dut("small", S_HT, S_VT, S_HA, S_VA, S_HA + S_HF, S_HA + S_HF + S_HS,
              S_VA + S_VF, S_VA + S_VF + S_VS, t,
              s_px, s_pxn, s_py, s_pyn, s_fr, s_hs, s_vs, s_vis, s_fs, s_pix, chk_pix);
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      t++;
      @(negedge clk);
      check_all(1'b1);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    t     = 0;
    repeat (3) @(negedge clk);
    check_all(1'b0);
    rst_n = 1'b1;

    // Run into the fourth frame of the short raster, then reset mid-frame
    run(3 * S_F + int'($urandom_range(S_HT * 200, S_F - 2)));
    check("small.frame_before_reset", s_fr, 3);

    #($urandom_range(1, 3));
    rst_n = 1'b0;
    #1;
    t = 0;
    check_all(1'b0);
    repeat ($urandom_range(1, 4)) begin
      @(posedge clk);
      @(negedge clk);
      check_all(1'b0);
    end
    rst_n = 1'b1;

    // One complete frame after release plus a few lines of the next
    run(S_F + int'($urandom_range(20, 3 * S_HT)));
    check("small.frame_after_restart", s_fr, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
